// File: rtl/bnn_pkg.sv
// Shared definitions for the binary MLP engine: FSM state encoding,
// configuration address map helpers and constant-function utilities.
package bnn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HIDDEN = 2'd1,
        OUTPUT = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Hidden weight rows always start the configuration map.
    localparam int HID_ROW_BASE = 0;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Output weight rows follow the hidden rows.
    function automatic int out_row_base(input int n_hid);
        return n_hid;
    endfunction

    // Hidden biases follow the output rows.
    function automatic int bias_base(input int n_hid, input int n_out);
        return n_hid + n_out;
    endfunction

    // Programmable thresholds (when present) follow the biases.
    function automatic int thresh_base(input int n_hid, input int n_out);
        return n_hid + n_out + n_hid;
    endfunction

endpackage

// File: rtl/bnn_xnor_popcount.sv
// Combinational XNOR-popcount: counts the bit positions where a and b agree.
// Shared by the hidden and output layers of bnn_mlp_engine.
module bnn_xnor_popcount
    import bnn_pkg::*;
#(
    parameter int W = 4
)(
    input  logic [W-1:0]              a,
    input  logic [W-1:0]              b,
    output logic [clog2(W+1)-1:0]     count
);

    localparam int CW = clog2(W + 1);

    logic [W-1:0] match;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_match
            assign match[gi] = ~(a[gi] ^ b[gi]);
        end
    endgenerate

    // Sum the agreement bits.
    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + CW'(match[i]);
        end
    end

endmodule

// File: rtl/bnn_mlp_engine.sv
// Binary two-layer MLP classifier. Features are binarized against
// thresholds, one hidden neuron is evaluated per cycle, then one output
// score per cycle with a running argmax (ties go to the lowest index).
// Optional macro BNN_PROG_THRESH_EN makes the binarization thresholds
// writable through the configuration port; otherwise they are fixed at
// 2^(FEAT_W-1).
module bnn_mlp_engine
    import bnn_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int FEAT_W = 4,
    parameter int N_HID  = 4,
    parameter int N_OUT  = 2,
    parameter int BIAS_W = 4,
    localparam int CLS_W = clog2(N_OUT),
    localparam int DW    = max2(max2(N_IN, N_HID), max2(BIAS_W, FEAT_W))
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic [N_IN*FEAT_W-1:0] feat_in,
    input  logic                   start,
    output logic                   busy,
    output logic                   valid,
    output logic [CLS_W-1:0]       class_out,
    output logic [N_HID-1:0]       hidden_out,
    input  logic                   cfg_we,
    input  logic [7:0]             cfg_addr,
    input  logic [DW-1:0]          cfg_wdata
);

    // Shared popcount width covers both layers; the unused padding bits of
    // the narrower layer agree (0 vs 0) and are subtracted back out.
    localparam int PW = max2(N_IN, N_HID);
    localparam int CW = clog2(PW + 1);
    localparam int NW = clog2(N_IN + 1);
    localparam int SW = NW + BIAS_W + 1;
    localparam int IW = clog2(max2(N_HID, N_OUT));
    localparam logic [CW-1:0] PAD_HID = CW'(PW - N_IN);
    localparam logic [CW-1:0] PAD_OUT = CW'(PW - N_HID);
    localparam logic [FEAT_W-1:0] THR_DEF = FEAT_W'(1 << (FEAT_W - 1));
    localparam int OUT_BASE  = out_row_base(N_HID);
    localparam int BIAS_BASE = bias_base(N_HID, N_OUT);

    state_t            state_reg, state_next;
    logic [IW-1:0]     idx_reg, idx_next;
    logic              last_hid, last_out;

    logic [N_IN-1:0]   hid_w_reg [N_HID];
    logic [N_HID-1:0]  out_w_reg [N_OUT];
    logic [BIAS_W-1:0] bias_reg  [N_HID];
    logic [FEAT_W-1:0] thr_val   [N_IN];

    logic [N_IN-1:0]   x_bin;
    logic [N_IN-1:0]   x_reg;
    logic [N_HID-1:0]  act_reg;
    logic [CW-1:0]     max_reg;
    logic [CLS_W-1:0]  best_reg;
    logic              valid_reg;
    logic [CLS_W-1:0]  cls_reg;
    logic [N_HID-1:0]  hid_reg;

    logic [N_IN-1:0]   row_hid;
    logic [N_HID-1:0]  row_out;
    logic [BIAS_W-1:0] bias_sel;
    logic [PW-1:0]     pc_a, pc_b;
    logic [CW-1:0]     pc_count;
    logic [NW-1:0]     hid_cnt;
    logic signed [SW-1:0] hid_sum;
    logic              act_bit;
    logic [CW-1:0]     score;
    logic              cfg_wr;

    assign last_hid = (idx_reg == IW'(N_HID - 1));
    assign last_out = (idx_reg == IW'(N_OUT - 1));
    assign cfg_wr   = cfg_we && ena && (state_reg == IDLE);

    // Binarize each feature against its threshold.
    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_bin
            assign x_bin[gi] = (feat_in[gi*FEAT_W +: FEAT_W] >= thr_val[gi]);
        end
    endgenerate

`ifdef BNN_PROG_THRESH_EN
    localparam int THR_BASE = thresh_base(N_HID, N_OUT);
    logic [FEAT_W-1:0] thr_reg [N_IN];

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_thr
            assign thr_val[gi] = thr_reg[gi];
        end
    endgenerate

    // Programmable thresholds, reset to the mid-scale default.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_IN; k++) thr_reg[k] <= THR_DEF;
        end else if (cfg_wr) begin
            for (int k = 0; k < N_IN; k++) begin
                if (cfg_addr == 8'(THR_BASE + k)) thr_reg[k] <= cfg_wdata[FEAT_W-1:0];
            end
        end
    end
`else
    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_thr
            assign thr_val[gi] = THR_DEF;
        end
    endgenerate
`endif

    // Weight and bias register file; writable only while idle and enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_HID; k++) hid_w_reg[k] <= '0;
            for (int k = 0; k < N_OUT; k++) out_w_reg[k] <= '0;
            for (int k = 0; k < N_HID; k++) bias_reg[k]  <= '0;
        end else if (cfg_wr) begin
            for (int k = 0; k < N_HID; k++) begin
                if (cfg_addr == 8'(HID_ROW_BASE + k)) hid_w_reg[k] <= cfg_wdata[N_IN-1:0];
            end
            for (int k = 0; k < N_OUT; k++) begin
                if (cfg_addr == 8'(OUT_BASE + k)) out_w_reg[k] <= cfg_wdata[N_HID-1:0];
            end
            for (int k = 0; k < N_HID; k++) begin
                if (cfg_addr == 8'(BIAS_BASE + k)) bias_reg[k] <= cfg_wdata[BIAS_W-1:0];
            end
        end
    end

    // FSM state and step-index register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    // FSM next-state: idle -> hidden sweep -> output sweep -> done.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        if (ena) begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_next = HIDDEN;
                        idx_next   = '0;
                    end
                end
                HIDDEN: begin
                    if (last_hid) begin
                        state_next = OUTPUT;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_reg + IW'(1);
                    end
                end
                OUTPUT: begin
                    if (last_out) begin
                        state_next = DONE;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_reg + IW'(1);
                    end
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                    idx_next   = '0;
                end
            endcase
        end
    end

    // Select the weight row and bias for the current step and steer the
    // shared popcount operands to the active layer.
    always_comb begin
        row_hid  = '0;
        row_out  = '0;
        bias_sel = '0;
        for (int k = 0; k < N_HID; k++) begin
            if (idx_reg == IW'(k)) begin
                row_hid  = hid_w_reg[k];
                bias_sel = bias_reg[k];
            end
        end
        for (int k = 0; k < N_OUT; k++) begin
            if (idx_reg == IW'(k)) row_out = out_w_reg[k];
        end
        pc_a = '0;
        pc_b = '0;
        if (state_reg == OUTPUT) begin
            pc_a[N_HID-1:0] = act_reg;
            pc_b[N_HID-1:0] = row_out;
        end else begin
            pc_a[N_IN-1:0] = x_reg;
            pc_b[N_IN-1:0] = row_hid;
        end
    end

    bnn_xnor_popcount #(.W(PW)) u_popcount (
        .a     (pc_a),
        .b     (pc_b),
        .count (pc_count)
    );

    // Hidden activation: agreement count plus signed bias, sign bit inverted.
    assign hid_cnt = NW'(pc_count - PAD_HID);
    assign hid_sum = $signed({{(SW-NW){1'b0}}, hid_cnt})
                   + $signed({{(SW-BIAS_W){bias_sel[BIAS_W-1]}}, bias_sel});
    assign act_bit = ~hid_sum[SW-1];
    assign score   = pc_count - PAD_OUT;

    // Inference datapath: latch inputs, accumulate activations, track argmax,
    // publish results on leaving DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg     <= '0;
            act_reg   <= '0;
            max_reg   <= '0;
            best_reg  <= '0;
            valid_reg <= 1'b0;
            cls_reg   <= '0;
            hid_reg   <= '0;
        end else if (ena) begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        x_reg     <= x_bin;
                        valid_reg <= 1'b0;
                        cls_reg   <= '0;
                        hid_reg   <= '0;
                    end
                end
                HIDDEN: begin
                    for (int k = 0; k < N_HID; k++) begin
                        if (idx_reg == IW'(k)) act_reg[k] <= act_bit;
                    end
                end
                OUTPUT: begin
                    if ((idx_reg == '0) || (score > max_reg)) begin
                        max_reg  <= score;
                        best_reg <= CLS_W'(idx_reg);
                    end
                end
                DONE: begin
                    valid_reg <= 1'b1;
                    cls_reg   <= best_reg;
                    hid_reg   <= act_reg;
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state_reg != IDLE);
    assign valid      = valid_reg;
    assign class_out  = valid_reg ? cls_reg : '0;
    assign hidden_out = valid_reg ? hid_reg : '0;

endmodule

// File: tb/tb_bnn_mlp_engine.sv
// Self-checking bench for bnn_mlp_engine at default parameters.
// Expected results come from a behavioural model of the classifier rules.
module tb_bnn_mlp_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic [15:0] feat_in = '0;
    logic        start = 1'b0;
    logic        busy;
    logic        valid;
    logic [0:0]  class_out;
    logic [3:0]  hidden_out;
    logic        cfg_we = 1'b0;
    logic [7:0]  cfg_addr = '0;
    logic [3:0]  cfg_wdata = '0;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    logic [3:0] m_hw [4];
    logic [3:0] m_ow [2];
    int         m_bias [4];
    int         m_thr [4];

    bnn_mlp_engine dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .feat_in    (feat_in),
        .start      (start),
        .busy       (busy),
        .valid      (valid),
        .class_out  (class_out),
        .hidden_out (hidden_out),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_hw[i] = '0; m_bias[i] = 0; m_thr[i] = 8;
        end
        for (int i = 0; i < 2; i++) m_ow[i] = '0;
    endfunction

    // Classifier rules: binarize, count agreements, add bias, argmax.
    function automatic void model(input logic [15:0] f, output logic [3:0] hid, output int cls);
        logic [3:0] x;
        int agree, sc, best;
        for (int i = 0; i < 4; i++) x[i] = (int'(f[i*4 +: 4]) >= m_thr[i]);
        for (int h = 0; h < 4; h++) begin
            agree = 0;
            for (int i = 0; i < 4; i++) if (x[i] == m_hw[h][i]) agree++;
            hid[h] = (agree + m_bias[h] >= 0);
        end
        best = -1; cls = 0;
        for (int o = 0; o < 2; o++) begin
            sc = 0;
            for (int j = 0; j < 4; j++) if (hid[j] == m_ow[o][j]) sc++;
            if (sc > best) begin best = sc; cls = o; end
        end
    endfunction

    // Idle-time configuration write, mirrored into the model's address map.
    task automatic cfg_write(input int addr, input logic [3:0] data);
        cfg_we = 1'b1; cfg_addr = 8'(addr); cfg_wdata = data;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        if (addr < 4) m_hw[addr] = data;
        else if (addr < 6) m_ow[addr-4] = data;
        else if (addr < 10) m_bias[addr-6] = int'($signed(data));
`ifdef BNN_PROG_THRESH_EN
        else if (addr < 14) m_thr[addr-10] = int'(data);
`endif
        $display("cfg  addr=%0d data=0x%0h", addr, data);
    endtask

    task automatic run_inf(input logic [15:0] f, input bit disturb, input bit gap, input string tag);
        logic [3:0] eh;
        int ec, cyc;
        model(f, eh, ec);
        feat_in = f; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        feat_in = 16'($urandom);
        check({tag, ".busy_on"}, 32'(busy), 32'd1);
        check({tag, ".valid_clr"}, 32'(valid), 32'd0);
        if (gap) begin
            ena = 1'b0;
            repeat (4) begin @(posedge clk); #1; end
            check({tag, ".gap_busy"}, 32'(busy), 32'd1);
            check({tag, ".gap_valid"}, 32'(valid), 32'd0);
            ena = 1'b1;
        end
        cyc = 0;
        while (!valid && cyc < 20) begin
            if (disturb && cyc == 2) begin
                start = 1'b1; cfg_we = 1'b1; cfg_addr = 8'd0; cfg_wdata = 4'h0;
            end
            @(posedge clk); #1;
            cyc++;
            start = 1'b0; cfg_we = 1'b0;
        end
        check({tag, ".latency"}, 32'(cyc), 32'd7);
        check({tag, ".hidden"}, 32'(hidden_out), 32'(eh));
        check({tag, ".class"}, 32'(class_out), 32'(ec));
        check({tag, ".busy_off"}, 32'(busy), 32'd0);
        $display("inf  %s feat=0x%04h hidden=%b class=%0d exp_hidden=%b exp_class=%0d lat=%0d",
                 tag, f, hidden_out, class_out, eh, ec, cyc);
        if (disturb) begin
            repeat (3) begin @(posedge clk); #1; end
            check({tag, ".no_restart"}, 32'(busy), 32'd0);
            check({tag, ".valid_hold"}, 32'(valid), 32'd1);
            check({tag, ".hidden_hold"}, 32'(hidden_out), 32'(eh));
        end
    endtask

    initial begin
        logic [3:0] exp_b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.valid", 32'(valid), 32'd0);
        check("rst.class", 32'(class_out), 32'd0);
        check("rst.hidden", 32'(hidden_out), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero weights and biases after reset
        run_inf(16'($urandom), 1'b0, 1'b0, "zero_cfg");

        // Directed weight set: hidden rows 1111, biases -2, out rows {1111,0000}
        for (int h = 0; h < 4; h++) cfg_write(h, 4'hF);
        for (int h = 0; h < 4; h++) cfg_write(6 + h, 4'hE);
        cfg_write(4, 4'hF);
        cfg_write(5, 4'h0);
        run_inf(16'hFFFF, 1'b0, 1'b0, "all_ones");
        check("all_ones.hidden_const", 32'(hidden_out), 32'hF);
        run_inf(16'h0000, 1'b0, 1'b0, "all_zero");
        check("all_zero.class_const", 32'(class_out), 32'd1);

        // Tie between equal output rows resolves to index 0
        cfg_write(5, 4'hF);
        run_inf(16'hFFFF, 1'b0, 1'b0, "tie");
        run_inf(16'h8787, 1'b0, 1'b0, "mixed_7878");

        // Start and cfg write during busy are ignored
        run_inf(16'h0F0F, 1'b1, 1'b0, "busy_disturb");
        run_inf(16'h0F0F, 1'b0, 1'b0, "after_disturb");

        // ena low: idle start and cfg write ignored, outputs held
        ena = 1'b0; start = 1'b1; cfg_we = 1'b1; cfg_addr = 8'd0; cfg_wdata = 4'h0;
        repeat (3) begin @(posedge clk); #1; end
        check("ena_off.busy", 32'(busy), 32'd0);
        check("ena_off.valid_hold", 32'(valid), 32'd1);
        start = 1'b0; cfg_we = 1'b0; ena = 1'b1;
        run_inf(16'hF0F0, 1'b0, 1'b1, "ena_gap");

        // Randomized weights, biases and features
        for (int r = 0; r < 12; r++) begin
            for (int a = 0; a < 10; a++) cfg_write(a, 4'($urandom_range(0, 15)));
            run_inf(16'($urandom), 1'b0, 1'b0, $sformatf("rand%0d", r));
        end

        // Reset during an inference
        feat_in = 16'hFFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.valid", 32'(valid), 32'd0);
        check("midrst.class", 32'(class_out), 32'd0);
        check("midrst.hidden", 32'(hidden_out), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        run_inf(16'($urandom), 1'b0, 1'b0, "post_rst");
        check("post_rst.hidden_const", 32'(hidden_out), 32'hF);

        // Threshold write: effective only when thresholds are programmable
        cfg_write(10, 4'd3);
        cfg_write(0, 4'b0001);
        cfg_write(6, 4'hC);
        run_inf(16'h0004, 1'b0, 1'b0, "thresh");
`ifdef BNN_PROG_THRESH_EN
        exp_b0 = 4'd1;
`else
        exp_b0 = 4'd0;
`endif
        check("thresh.bit0", 32'(hidden_out[0]), 32'(exp_b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
